// File: rtl/io_map_pkg.sv
// Shared memory map for the board I/O responders: bus width, register
// addresses, control/status bit positions and the status-word packer.
package io_map_pkg;

    localparam int IO_DBITS = 32;

    localparam logic [31:0] IO_ADDR_HEX   = 32'hF000_0000;
    localparam logic [31:0] IO_ADDR_LEDR  = 32'hF000_0004;
    localparam logic [31:0] IO_ADDR_KEY   = 32'hF000_0010;
    localparam logic [31:0] IO_ADDR_SW    = 32'hF000_0014;
    localparam logic [31:0] IO_ADDR_KCTRL = 32'hF000_0110;
    localparam logic [31:0] IO_ADDR_SCTRL = 32'hF000_0114;

    localparam int CTRL_READY_BIT = 0;
    localparam int CTRL_OVR_BIT   = 2;
    localparam int CTRL_IE_BIT    = 8;

    typedef enum logic [2:0] {
        SEL_NONE  = 3'd0,
        SEL_KEY   = 3'd1,
        SEL_SW    = 3'd2,
        SEL_KCTRL = 3'd3,
        SEL_SCTRL = 3'd4
    } reg_sel_t;

    typedef struct packed {
        logic ovr;
        logic ready;
    } dev_stat_t;

    function automatic logic [IO_DBITS-1:0] ctrl_word(input dev_stat_t st, input logic ie);
        logic [IO_DBITS-1:0] w;
        w                 = {IO_DBITS{1'b0}};
        w[CTRL_READY_BIT] = st.ready;
        w[CTRL_OVR_BIT]   = st.ovr;
        w[CTRL_IE_BIT]    = ie;
        return w;
    endfunction

endpackage

// File: rtl/key_sw_io_responder_sync_debounce.sv
// Two-flop input synchroniser with an optional stability filter: with CYCLES > 0
// the output only follows the synced value once it has held for CYCLES cycles.
module sync_debounce #(
    parameter int               WIDTH     = 1,
    parameter int               CYCLES    = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Metastability guard on the raw pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (CYCLES == 0) begin : g_sync_only
            assign q_o = sync2_q;
        end else begin : g_debounce
            localparam int            CW      = $clog2(CYCLES + 1);
            localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES);
            localparam logic [CW:0]   RUN_TGT = (CW + 1)'(CYCLES);
            localparam logic [CW:0]   RUN_ONE = (CW + 1)'(1);

            logic [WIDTH-1:0] cand_q;
            logic [WIDTH-1:0] stable_q;
            logic [CW-1:0]    cnt_q;
            logic [CW-1:0]    cnt_d;
            logic [CW:0]      run_s;
            logic             accept_s;

            // run_s counts the current cycle, so acceptance lands on the Nth stable cycle.
            always_comb begin
                if (sync2_q == cand_q) begin
                    run_s = {1'b0, cnt_q} + RUN_ONE;
                end else begin
                    run_s = RUN_ONE;
                end
                accept_s = (run_s >= RUN_TGT);
                if (accept_s) begin
                    cnt_d = CNT_MAX;
                    q_o   = sync2_q;
                end else begin
                    cnt_d = run_s[CW-1:0];
                    q_o   = stable_q;
                end
            end

            // Candidate, saturating run counter and last accepted value.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cand_q   <= RESET_VAL;
                    stable_q <= RESET_VAL;
                    cnt_q    <= {CW{1'b0}};
                end else begin
                    cand_q   <= sync2_q;
                    stable_q <= q_o;
                    cnt_q    <= cnt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/key_sw_io_responder.sv
// KEY/SW memory-mapped responder: conditioned inputs latched into data registers
// with sticky Ready/Overrun status. KEY_SW_IO_IRQ_EN adds IE bits and a registered irq.
module key_sw_io_responder
    import io_map_pkg::*;
#(
    parameter int               DBITS           = IO_DBITS,
    parameter logic [DBITS-1:0] ADDR_KEY        = IO_ADDR_KEY,
    parameter logic [DBITS-1:0] ADDR_SW         = IO_ADDR_SW,
    parameter logic [DBITS-1:0] ADDR_KCTRL      = IO_ADDR_KCTRL,
    parameter logic [DBITS-1:0] ADDR_SCTRL      = IO_ADDR_SCTRL,
    parameter int               DEBOUNCE_CYCLES = 10000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DBITS-1:0] addr,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [DBITS-1:0] wr_data,
    output logic [DBITS-1:0] rd_data,
    output logic             hit,
    input  logic [3:0]       key_in,
    input  logic [9:0]       sw_in,
    output logic             irq
);

    logic [3:0] k_cond_s;
    logic [9:0] s_cond_s;
    reg_sel_t   sel_s;
    logic [3:0] kdata_q, kdata_d;
    logic [9:0] sdata_q, sdata_d;
    dev_stat_t  kstat_q, kstat_d;
    dev_stat_t  sstat_q, sstat_d;
    logic       k_chg_s, s_chg_s;
    logic       k_rd_s, s_rd_s;
    logic       kctrl_wr_s, sctrl_wr_s;
    logic       kie_s, sie_s;
    logic       unused_wr_s;

    assign unused_wr_s = ^wr_data;

    sync_debounce #(
        .WIDTH    (4),
        .CYCLES   (0),
        .RESET_VAL(4'hF)
    ) u_key_cond (
        .clk  (clk),
        .rst_n(reset_n),
        .d_i  (key_in),
        .q_o  (k_cond_s)
    );

    sync_debounce #(
        .WIDTH    (10),
        .CYCLES   (DEBOUNCE_CYCLES),
        .RESET_VAL(10'd0)
    ) u_sw_cond (
        .clk  (clk),
        .rst_n(reset_n),
        .d_i  (sw_in),
        .q_o  (s_cond_s)
    );

    // A data read consumes the old value, so a simultaneous change is not an overrun.
    function automatic dev_stat_t next_stat(input dev_stat_t cur, input logic chg,
                                            input logic rd_clr, input logic ovr_clr);
        dev_stat_t nxt;
        nxt.ready = chg | (cur.ready & ~rd_clr);
        nxt.ovr   = (chg & cur.ready & ~rd_clr) | (cur.ovr & ~ovr_clr);
        return nxt;
    endfunction

    // Address decode.
    always_comb begin
        if (addr == ADDR_KEY) begin
            sel_s = SEL_KEY;
        end else if (addr == ADDR_SW) begin
            sel_s = SEL_SW;
        end else if (addr == ADDR_KCTRL) begin
            sel_s = SEL_KCTRL;
        end else if (addr == ADDR_SCTRL) begin
            sel_s = SEL_SCTRL;
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // Read data mux back to the MEM stage.
    always_comb begin
        hit     = 1'b1;
        rd_data = {DBITS{1'b0}};
        case (sel_s)
            SEL_KEY:   rd_data = DBITS'(kdata_q);
            SEL_SW:    rd_data = DBITS'(sdata_q);
            SEL_KCTRL: rd_data = DBITS'(ctrl_word(kstat_q, kie_s));
            SEL_SCTRL: rd_data = DBITS'(ctrl_word(sstat_q, sie_s));
            default:   hit = 1'b0;
        endcase
    end

    // Change capture and status next-state.
    always_comb begin
        k_rd_s     = rd_en && (sel_s == SEL_KEY);
        s_rd_s     = rd_en && (sel_s == SEL_SW);
        kctrl_wr_s = wr_en && (sel_s == SEL_KCTRL);
        sctrl_wr_s = wr_en && (sel_s == SEL_SCTRL);
        k_chg_s    = (k_cond_s != kdata_q);
        s_chg_s    = (s_cond_s != sdata_q);
        if (k_chg_s) begin
            kdata_d = k_cond_s;
        end else begin
            kdata_d = kdata_q;
        end
        if (s_chg_s) begin
            sdata_d = s_cond_s;
        end else begin
            sdata_d = sdata_q;
        end
        kstat_d = next_stat(kstat_q, k_chg_s, k_rd_s, kctrl_wr_s && !wr_data[CTRL_OVR_BIT]);
        sstat_d = next_stat(sstat_q, s_chg_s, s_rd_s, sctrl_wr_s && !wr_data[CTRL_OVR_BIT]);
    end

    // Data and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kdata_q <= 4'hF;
            sdata_q <= 10'd0;
            kstat_q <= '{ovr: 1'b0, ready: 1'b0};
            sstat_q <= '{ovr: 1'b0, ready: 1'b0};
        end else begin
            kdata_q <= kdata_d;
            sdata_q <= sdata_d;
            kstat_q <= kstat_d;
            sstat_q <= sstat_d;
        end
    end

`ifdef KEY_SW_IO_IRQ_EN
    logic kie_q, sie_q, irq_q;

    // Interrupt enables and the irq flop, which lags the Ready bits by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kie_q <= 1'b0;
            sie_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (kctrl_wr_s) begin
                kie_q <= wr_data[CTRL_IE_BIT];
            end else begin
                kie_q <= kie_q;
            end
            if (sctrl_wr_s) begin
                sie_q <= wr_data[CTRL_IE_BIT];
            end else begin
                sie_q <= sie_q;
            end
            irq_q <= (kie_q & kstat_q.ready) | (sie_q & sstat_q.ready);
        end
    end

    assign kie_s = kie_q;
    assign sie_s = sie_q;
    assign irq   = irq_q;
`else
    assign kie_s = 1'b0;
    assign sie_s = 1'b0;
    assign irq   = 1'b0;
`endif

endmodule

// File: tb/tb_key_sw_io_responder.sv
// Directed bench for key_sw_io_responder (DEBOUNCE_CYCLES = 4) with a queue of
// expected register reads; irq expectations follow KEY_SW_IO_IRQ_EN.
module tb_key_sw_io_responder;

    localparam logic [31:0] A_KEY   = 32'hF000_0010;
    localparam logic [31:0] A_SW    = 32'hF000_0014;
    localparam logic [31:0] A_KCTRL = 32'hF000_0110;
    localparam logic [31:0] A_SCTRL = 32'hF000_0114;
    localparam logic [31:0] A_UNMAP = 32'hF000_0018;
`ifdef KEY_SW_IO_IRQ_EN
    localparam logic        IRQ_ON  = 1'b1;
    localparam logic [31:0] IE_WORD = 32'h100;
`else
    localparam logic        IRQ_ON  = 1'b0;
    localparam logic [31:0] IE_WORD = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        hit;
    logic [3:0]  key_in;
    logic [9:0]  sw_in;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] data;
        logic        hit;
    } exp_t;

    exp_t sb[$];

    key_sw_io_responder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .addr   (addr),
        .rd_en  (rd_en),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .hit    (hit),
        .key_in (key_in),
        .sw_in  (sw_in),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input string tag, input logic [31:0] a,
                             input logic [31:0] d, input logic h);
        exp_t e;
        e.tag  = tag;
        e.a    = a;
        e.data = d;
        e.hit  = h;
        sb.push_back(e);
    endtask

    // Present each queued address with no strobes and compare the combinational response.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e     = sb.pop_front();
            addr  = e.a;
            rd_en = 1'b0;
            wr_en = 1'b0;
            #1;
            n_assert++;
            assert (rd_data === e.data) else begin
                n_fail++;
                $error("FAIL %s rd_data: got %h expected %h", e.tag, rd_data, e.data);
            end
            n_assert++;
            assert (hit === e.hit) else begin
                n_fail++;
                $error("FAIL %s hit: got %b expected %b", e.tag, hit, e.hit);
            end
        end
    endtask

    task automatic check_irq(input string tag, input logic exp);
        n_assert++;
        assert (irq === exp) else begin
            n_fail++;
            $error("FAIL %s irq: got %b expected %b", tag, irq, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        addr    = 32'h0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 32'h0;
        key_in  = 4'hE;
        sw_in   = 10'd0;

        // Reset state
        tick(3);
        expect_rd("rst_key", A_KEY, 32'hF, 1'b1);
        expect_rd("rst_kctrl", A_KCTRL, 32'h0, 1'b1);
        expect_rd("rst_sw", A_SW, 32'h0, 1'b1);
        drain();
        check_irq("rst_irq", 1'b0);

        // Key change: 3-cycle latency
        reset_n = 1'b1;
        tick(2);
        expect_rd("key_lat2", A_KEY, 32'hF, 1'b1);
        drain();
        tick(1);
        expect_rd("key_lat3", A_KEY, 32'hE, 1'b1);
        expect_rd("kctrl_ready", A_KCTRL, 32'h1, 1'b1);
        drain();
        addr  = A_KEY;
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        expect_rd("kctrl_rdclr", A_KCTRL, 32'h0, 1'b1);
        drain();

        // Overrun and its clear
        key_in = 4'hC;
        tick(3);
        expect_rd("key_c", A_KEY, 32'hC, 1'b1);
        expect_rd("kctrl_c", A_KCTRL, 32'h1, 1'b1);
        drain();
        key_in = 4'h8;
        tick(3);
        expect_rd("key_8", A_KEY, 32'h8, 1'b1);
        expect_rd("kctrl_ovr", A_KCTRL, 32'h5, 1'b1);
        drain();
        addr    = A_KCTRL;
        wr_en   = 1'b1;
        wr_data = 32'h0;
        tick(1);
        wr_en = 1'b0;
        expect_rd("kctrl_wr0", A_KCTRL, 32'h1, 1'b1);
        drain();
        addr    = A_KCTRL;
        wr_en   = 1'b1;
        wr_data = 32'h4;
        tick(1);
        wr_en = 1'b0;
        expect_rd("kctrl_wr4", A_KCTRL, 32'h1, 1'b1);
        drain();
        addr    = A_KEY;
        wr_en   = 1'b1;
        wr_data = 32'h5;
        tick(1);
        wr_en = 1'b0;
        expect_rd("key_wr_ign", A_KEY, 32'h8, 1'b1);
        expect_rd("kctrl_wr_ign", A_KCTRL, 32'h1, 1'b1);
        drain();

        // Overrun set and clear on the same edge: set wins
        key_in = 4'h0;
        tick(2);
        addr    = A_KCTRL;
        wr_en   = 1'b1;
        wr_data = 32'h0;
        tick(1);
        wr_en = 1'b0;
        expect_rd("key_0", A_KEY, 32'h0, 1'b1);
        expect_rd("kctrl_setwins", A_KCTRL, 32'h5, 1'b1);
        drain();
        addr    = A_KCTRL;
        wr_en   = 1'b1;
        wr_data = 32'h0;
        tick(1);
        wr_en = 1'b0;
        expect_rd("kctrl_clr2", A_KCTRL, 32'h1, 1'b1);
        drain();

        // Read and write strobes together on a data address
        addr    = A_KEY;
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 32'hF;
        tick(1);
        rd_en = 1'b0;
        wr_en = 1'b0;
        expect_rd("key_rdwr", A_KEY, 32'h0, 1'b1);
        expect_rd("kctrl_rdwr", A_KCTRL, 32'h0, 1'b1);
        drain();

        // Debounce: bounce faster than the filter, then settle
        for (int i = 0; i < 5; i++) begin
            sw_in = 10'h008;
            tick(2);
            expect_rd("sw_bounce_hi", A_SW, 32'h0, 1'b1);
            drain();
            sw_in = 10'h000;
            tick(2);
            expect_rd("sw_bounce_lo", A_SW, 32'h0, 1'b1);
            drain();
        end
        sw_in = 10'h008;
        tick(5);
        expect_rd("sw_lat5", A_SW, 32'h0, 1'b1);
        expect_rd("sctrl_lat5", A_SCTRL, 32'h0, 1'b1);
        drain();
        tick(1);
        expect_rd("sw_lat6", A_SW, 32'h8, 1'b1);
        expect_rd("sctrl_lat6", A_SCTRL, 32'h1, 1'b1);
        drain();

        // Data read on the update edge: Ready kept, no overrun
        sw_in = 10'h010;
        tick(5);
        addr  = A_SW;
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        expect_rd("sw_simul", A_SW, 32'h10, 1'b1);
        expect_rd("sctrl_simul", A_SCTRL, 32'h1, 1'b1);
        expect_rd("unmapped", A_UNMAP, 32'h0, 1'b0);
        drain();

        // Interrupt path
        addr  = A_SW;
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        expect_rd("sctrl_rdclr", A_SCTRL, 32'h0, 1'b1);
        drain();
        addr    = A_SCTRL;
        wr_en   = 1'b1;
        wr_data = 32'h100;
        tick(1);
        wr_en = 1'b0;
        expect_rd("sctrl_ie", A_SCTRL, IE_WORD, 1'b1);
        drain();
        check_irq("irq_idle", 1'b0);
        sw_in = 10'h020;
        tick(6);
        expect_rd("sw_irq", A_SW, 32'h20, 1'b1);
        expect_rd("sctrl_irq", A_SCTRL, IE_WORD | 32'h1, 1'b1);
        drain();
        check_irq("irq_ready_edge", 1'b0);
        tick(1);
        check_irq("irq_set", IRQ_ON);
        addr  = A_SW;
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check_irq("irq_lag", IRQ_ON);
        tick(1);
        check_irq("irq_clr", 1'b0);

        // Reset in the middle of a debounce run
        sw_in  = 10'h040;
        key_in = 4'hF;
        tick(3);
        reset_n = 1'b0;
        sw_in   = 10'h000;
        tick(2);
        reset_n = 1'b1;
        tick(10);
        expect_rd("sw_rst_mid", A_SW, 32'h0, 1'b1);
        expect_rd("sctrl_rst_mid", A_SCTRL, 32'h0, 1'b1);
        expect_rd("key_rst_mid", A_KEY, 32'hF, 1'b1);
        expect_rd("kctrl_rst_mid", A_KCTRL, 32'h0, 1'b1);
        drain();
        check_irq("irq_rst_mid", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/key_sw_io_responder.md
Name: key_sw_io_responder

Overview:
- Memory-mapped I/O responder on the processor data-memory bus, serving the KEY and SW address windows.
- Conditions the raw board inputs: 2-flop synchroniser on all inputs, plus debounce on switches.
- Latches changes into data registers and keeps sticky Ready/Overrun status per device.
- Returns read data to the data-memory output mux, with read side effects committed at the clock edge.

Parameters:
- DBITS, 32, bus data/address width
- ADDR_KEY, 32'hF0000010, KEY data register (read-only)
- ADDR_SW, 32'hF0000014, SW data register (read-only)
- ADDR_KCTRL, 32'hF0000110, KEY control/status register
- ADDR_SCTRL, 32'hF0000114, SW control/status register
- DEBOUNCE_CYCLES, 16'd10000, cycles SW must be stable before acceptance (minimum 1)

Ports:
- clk, in, 1, processor clock
- reset_n, in, 1, asynchronous active-low reset
- addr, in, DBITS, bus address
- rd_en, in, 1, bus read strobe (load instruction in MEM stage)
- wr_en, in, 1, bus write strobe
- wr_data, in, DBITS, bus write data
- rd_data, out, DBITS, read data, combinational from registers
- hit, out, 1, addr matches one of the four registers; selects rd_data in the MEM mux
- key_in, in, 4, raw KEY pins
- sw_in, in, 10, raw SW pins
- irq, out, 1, interrupt request (see Optional Feature)

Behaviour:
- Reset (reset_n low, asynchronous):
  - KDATA = 4'hF (keys released).
  - SDATA = 0.
  - All Ready, Overrun and IE bits = 0.
  - Debounce counters = 0.
  - Synchroniser flops = 4'hF for KEY, 0 for SW.
  - irq = 0.
- Input conditioning:
  - KEY: 2-flop sync only.
  - SW: 2-flop sync, then debounce. The candidate value must equal the synced value for DEBOUNCE_CYCLES consecutive cycles; the counter restarts on any mismatch.
  - Latency: raw edge to KDATA update = 3 cycles. Raw SW edge to SDATA update = 2 + DEBOUNCE_CYCLES cycles.
- Change capture (per device):
  - When the conditioned value differs from the data register, the data register loads the new value and Ready is set.
  - If Ready was already 1 and is not being cleared this cycle, Overrun is also set.
- Control/status register layout:
  - bit0 Ready (read-only).
  - bit2 Overrun (write 0 clears; write 1 ignored).
  - bit8 IE (read/write).
  - All other bits read 0.
- Reads:
  - hit and rd_data are combinational in the same cycle as addr; unmapped addresses give hit = 0 and rd_data = 0.
  - Data registers are zero-extended.
  - rd_en with addr == ADDR_KEY or ADDR_SW clears that device's Ready at the next edge.
  - Reading a control register has no side effect.
- Writes:
  - Writes to data addresses are ignored.
  - wr_en and rd_en together at the same address: the write takes effect and the read side effect is still applied.
- Simultaneous events:
  - Data read and new change in the same cycle: Ready stays 1, Overrun is not set (the old value was consumed); the data register takes the new value.
  - Overrun-clear write and new overrun in the same cycle: Overrun = 1 (set wins).
- Reset mid-debounce: the counter and candidate are discarded; no spurious Ready after release.
- Counter width: clog2(DEBOUNCE_CYCLES+1); saturates and never wraps.

Optional Feature:
- Macro: KEY_SW_IO_IRQ_EN.
- Defined: irq is registered, irq = (KCTRL.IE & KCTRL.Ready) | (SCTRL.IE & SCTRL.Ready), one cycle after the status change.
- Undefined: irq tied to 0, IE bits are not implemented (read 0, writes ignored), no interrupt flops are synthesised.

Decomposition:
- Shared package io_map_pkg holds:
  - the four address constants, the existing HEX/LEDR addresses, and DBITS;
  - control bit positions CTRL_READY_BIT = 0, CTRL_OVR_BIT = 2, CTRL_IE_BIT = 8.
- One sub-module, sync_debounce:
  - parameters WIDTH and CYCLES;
  - 2-flop sync plus stability counter;
  - instantiated with CYCLES = 0 (sync only) for KEY and CYCLES = DEBOUNCE_CYCLES for SW.

Test Plan (all with DEBOUNCE_CYCLES = 4):
- Reset: hold reset_n = 0 with key_in = 4'hE; read ADDR_KEY → rd_data = 32'hF, hit = 1. Read ADDR_KCTRL → 0.
- Key change: release reset, drop key_in to 4'hE → KDATA = 4'hE and KCTRL = 1 at cycle 3. rd_en on ADDR_KEY → KCTRL = 0 next cycle.
- Overrun: key_in 4'hE, then 4'hC, no read → KCTRL = 32'h5. Write 0 to ADDR_KCTRL → 32'h1. Write 32'h4 → remains 32'h1.
- Debounce: toggle sw_in bit3 every 2 cycles for 20 cycles, then hold 10'h008 → SDATA stays 0 during toggling and reads 32'h8 exactly 6 cycles after the final edge.
- Simultaneous: read ADDR_SW on the same edge SDATA updates → SCTRL = 1, Overrun = 0. Also check an unmapped addr 32'hF0000018 → hit = 0, rd_data = 0.
- Irq (KEY_SW_IO_IRQ_EN defined): write 32'h100 to ADDR_SCTRL, change SW → irq = 1 one cycle after Ready. Read ADDR_SW → irq = 0 next cycle. With the macro undefined, irq stays 0 throughout.
